// File: rtl/conv1d_pkg.sv
// Shared definitions for the 1-D convolution job sequencer: FSM encoding,
// default array geometry and the kernel-length legality check.
package conv1d_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int NUM_PE_DEF     = 16;
  localparam int DATA_WIDTH_DEF = 8;

  function automatic logic k_legal(input logic [4:0] k, input int num_pe);
    return (k != 5'd0) && (int'(k) <= num_pe);
  endfunction

endpackage

// File: rtl/conv1d_valid_delay.sv
// Shift register mirroring the array's pipeline depth; the tap selects the
// stage matching the active kernel length (tap_sel = 1 is the first stage).
module conv1d_valid_delay #(
  parameter int NUM_PE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       din,
  input  logic [4:0] tap_sel,
  output logic       tap
);

  logic [NUM_PE-1:0] vld_sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr <= '0;
    end else if (clear) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[NUM_PE-2:0], din};
    end
  end

  always_comb begin
    tap = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (tap_sel == 5'(i + 1)) tap = vld_sr[i];
    end
  end

endmodule

// File: rtl/conv1d_seq_ctrl.sv
// Job sequencer for the 1-D systolic convolution array: owns the coefficient
// file, streams N samples plus K-1 zero flush beats, and forwards N+K-1 results.
module conv1d_seq_ctrl
  import conv1d_pkg::*;
#(
  parameter int NUM_PE     = NUM_PE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         k_wr_en,
  input  logic [3:0]                   k_wr_addr,
  input  logic [DATA_WIDTH-1:0]        k_wr_data,
  input  logic                         start,
  input  logic [4:0]                   cfg_kernel_len,
  input  logic [CNT_WIDTH-1:0]         cfg_sample_count,
  input  logic                         abort,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic [4:0]                   active_pe_count,
  output logic [NUM_PE*DATA_WIDTH-1:0] kernel_row_flat,
  output logic [DATA_WIDTH-1:0]        x_in,
  output logic                         x_valid,
  input  logic [DATA_WIDTH-1:0]        y_out,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);

  localparam int OUT_W = CNT_WIDTH + 1;

  state_t                       state;
  logic [CNT_WIDTH-1:0]         n_reg;
  logic [CNT_WIDTH-1:0]         in_cnt;
  logic [CNT_WIDTH-1:0]         in_cnt_nxt;
  logic [4:0]                   flush_cnt;
  logic [4:0]                   flush_nxt;
  logic [OUT_W-1:0]             total;
  logic [OUT_W-1:0]             out_cnt;
  logic [OUT_W-1:0]             out_cnt_nxt;
  logic [DATA_WIDTH-1:0]        coef [NUM_PE];
  logic [NUM_PE*DATA_WIDTH-1:0] coef_flat;
  logic                         abort_hit;
  logic                         cfg_ok;
  logic                         launch;
  logic                         vld_tap;

  assign abort_hit   = abort && (state == STREAM || state == FLUSH || state == DRAIN);
  assign cfg_ok      = k_legal(cfg_kernel_len, NUM_PE) && (cfg_sample_count != '0);
  assign launch      = (state == IDLE) && start && cfg_ok;
  assign in_cnt_nxt  = in_cnt + CNT_WIDTH'(1);
  assign flush_nxt   = flush_cnt + 5'd1;
  assign out_cnt_nxt = out_cnt + OUT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_flat
      assign coef_flat[gi*DATA_WIDTH +: DATA_WIDTH] = coef[gi];
    end
  endgenerate

  // Coefficient file: host writes land only while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PE; i++) coef[i] <= '0;
    end else if (k_wr_en && state == IDLE) begin
      coef[k_wr_addr] <= k_wr_data;
    end
  end

  // Sequencer FSM. kernel_row_flat snapshots the file at launch, so a write
  // in the launch cycle commits to the file but not to the running job.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      n_reg           <= '0;
      in_cnt          <= '0;
      flush_cnt       <= '0;
      total           <= '0;
      active_pe_count <= '0;
      kernel_row_flat <= '0;
      x_in            <= '0;
      x_valid         <= 1'b0;
      s_ready         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      x_valid <= 1'b0;
      if (abort_hit) begin
        state   <= IDLE;
        s_ready <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                active_pe_count <= cfg_kernel_len;
                kernel_row_flat <= coef_flat;
                n_reg           <= cfg_sample_count;
                total           <= {1'b0, cfg_sample_count} + OUT_W'(cfg_kernel_len) - OUT_W'(1);
                in_cnt          <= '0;
                flush_cnt       <= '0;
                s_ready         <= 1'b1;
                busy            <= 1'b1;
                state           <= STREAM;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          STREAM: begin
            if (s_valid) begin
              x_in    <= s_data;
              x_valid <= 1'b1;
              in_cnt  <= in_cnt_nxt;
              if (in_cnt_nxt == n_reg) begin
                s_ready <= 1'b0;
                state   <= (active_pe_count == 5'd1) ? DRAIN : FLUSH;
              end
            end
          end
          FLUSH: begin
            x_in      <= '0;
            x_valid   <= 1'b1;
            flush_cnt <= flush_nxt;
            if (flush_nxt == active_pe_count - 5'd1) state <= DRAIN;
          end
          DRAIN: begin
            if (out_cnt == total) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  conv1d_valid_delay #(
    .NUM_PE (NUM_PE)
  ) u_valid_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (abort_hit),
    .din     (x_valid),
    .tap_sel (active_pe_count),
    .tap     (vld_tap)
  );

  // Result stage: the local tap, not the array, decides which y_out is real.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      out_cnt <= '0;
    end else if (launch) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      out_cnt <= '0;
    end else if (vld_tap && !abort_hit) begin
      m_valid <= 1'b1;
      m_data  <= y_out;
      m_last  <= (out_cnt_nxt == total);
      out_cnt <= out_cnt_nxt;
    end else begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv1d_seq_ctrl.sv
// Directed bench for conv1d_seq_ctrl with a behavioural K-cycle array model
// supplying y_out; expected results come from hand-computed job tables.
module tb_conv1d_seq_ctrl;

  localparam int NUM_PE = 16;
  localparam int DW     = 8;
  localparam int CW     = 16;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 k_wr_en = 1'b0;
  logic [3:0]           k_wr_addr = '0;
  logic [DW-1:0]        k_wr_data = '0;
  logic                 start = 1'b0;
  logic [4:0]           cfg_kernel_len = '0;
  logic [CW-1:0]        cfg_sample_count = '0;
  logic                 abort = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [DW-1:0]        s_data = '0;
  logic [4:0]           active_pe_count;
  logic [NUM_PE*DW-1:0] kernel_row_flat;
  logic [DW-1:0]        x_in;
  logic                 x_valid;
  logic [DW-1:0]        y_out;
  logic                 m_valid;
  logic [DW-1:0]        m_data;
  logic                 m_last;
  logic                 busy;
  logic                 done;
  logic                 cfg_err;

  always #5 clk = ~clk;

  conv1d_seq_ctrl #(
    .NUM_PE     (NUM_PE),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .k_wr_en          (k_wr_en),
    .k_wr_addr        (k_wr_addr),
    .k_wr_data        (k_wr_data),
    .start            (start),
    .cfg_kernel_len   (cfg_kernel_len),
    .cfg_sample_count (cfg_sample_count),
    .abort            (abort),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .active_pe_count  (active_pe_count),
    .kernel_row_flat  (kernel_row_flat),
    .x_in             (x_in),
    .x_valid          (x_valid),
    .y_out            (y_out),
    .m_valid          (m_valid),
    .m_data           (m_data),
    .m_last           (m_last),
    .busy             (busy),
    .done             (done),
    .cfg_err          (cfg_err)
  );

  // Array model: a beat presented on x_in appears on y_out K cycles later.
  logic [DW-1:0] hist [NUM_PE];
  logic [DW-1:0] pipe [NUM_PE];
  logic          busy_q;
  int            acc_m;
  logic [3:0]    ysel;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PE; i++) begin
        hist[i] <= '0;
        pipe[i] <= '0;
      end
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy;
      acc_m = int'(x_in) * int'(kernel_row_flat[DW-1:0]);
      for (int j = 1; j < NUM_PE; j++) begin
        if (j < int'(active_pe_count))
          acc_m = acc_m + int'(hist[j-1]) * int'(kernel_row_flat[j*DW +: DW]);
      end
      if (busy && !busy_q) begin
        for (int i = 0; i < NUM_PE; i++) hist[i] <= '0;
      end else if (x_valid) begin
        for (int i = 1; i < NUM_PE; i++) hist[i] <= hist[i-1];
        hist[0] <= x_in;
      end
      pipe[0] <= x_valid ? acc_m[DW-1:0] : '0;
      for (int i = 1; i < NUM_PE; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    ysel  = 4'(active_pe_count - 5'd1);
    y_out = (active_pe_count != 5'd0) ? pipe[ysel] : '0;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_x_valid"}, 32'(x_valid), 32'd0);
    chk({tag, "_x_in"}, 32'(x_in), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_m_last"}, 32'(m_last), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_active_pe_count"}, 32'(active_pe_count), 32'd0);
    n_cmp++;
    if (kernel_row_flat !== '0) begin
      n_bad++;
      $display("FAIL %s_kernel_row_flat: got %0h, expected 0", tag, kernel_row_flat);
    end
  endtask

  typedef struct {
    int            k;
    int            n;
    bit            bubble;
    logic [DW-1:0] c [3];
    logic [DW-1:0] x [4];
    logic [DW-1:0] y [6];
  } job_t;

  job_t jobs [4];

  task automatic load_coefs(input int j);
    for (int i = 0; i < 3; i++) begin
      k_wr_en   = 1'b1;
      k_wr_addr = 4'(i);
      k_wr_data = jobs[j].c[i];
      @(negedge clk);
    end
    k_wr_en = 1'b0;
  endtask

  task automatic run_job(input int j, input bit wr_test);
    int si, oi, total, done_cyc;
    int acc_cyc [4];
    load_coefs(j);
    cfg_kernel_len   = 5'(jobs[j].k);
    cfg_sample_count = CW'(jobs[j].n);
    start            = 1'b1;
    if (wr_test) begin
      k_wr_en   = 1'b1;
      k_wr_addr = 4'd0;
      k_wr_data = 8'd7;
    end
    @(negedge clk);
    start   = 1'b0;
    k_wr_en = 1'b0;
    chk($sformatf("job%0d_active_pe_count", j), 32'(active_pe_count), 32'(jobs[j].k));
    chk($sformatf("job%0d_coef0", j), 32'(kernel_row_flat[7:0]), 32'(jobs[j].c[0]));
    si = 0; oi = 0; done_cyc = 0;
    total = jobs[j].n + jobs[j].k - 1;
    for (int t = 1; t <= 100 && done_cyc == 0; t++) begin
      if (m_valid) begin
        if (oi < total) begin
          chk($sformatf("job%0d_m_data[%0d]", j, oi), 32'(m_data), 32'(jobs[j].y[oi]));
          chk($sformatf("job%0d_m_last[%0d]", j, oi), 32'(m_last), 32'(oi == total - 1));
          if (oi < jobs[j].n)
            chk($sformatf("job%0d_latency[%0d]", j, oi), 32'(t), 32'(acc_cyc[oi] + jobs[j].k + 2));
        end
        oi++;
      end
      if (done) done_cyc = t;
      k_wr_en = 1'b0;
      if (wr_test && t == 2) begin
        k_wr_en   = 1'b1;
        k_wr_addr = 4'd1;
        k_wr_data = 8'd9;
      end
      if (s_ready && si < jobs[j].n && !(jobs[j].bubble && (t % 2 == 0))) begin
        s_valid     = 1'b1;
        s_data      = jobs[j].x[si];
        acc_cyc[si] = t;
        si++;
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    k_wr_en = 1'b0;
    chk($sformatf("job%0d_done_seen", j), 32'(done_cyc != 0), 32'd1);
    chk($sformatf("job%0d_beats", j), 32'(oi), 32'(total));
    if (!jobs[j].bubble)
      chk($sformatf("job%0d_done_cycle", j), 32'(done_cyc), 32'(jobs[j].n + 2 * jobs[j].k + 2));
    chk($sformatf("job%0d_done_pulse", j), 32'(done), 32'd0);
    chk($sformatf("job%0d_busy_after", j), 32'(busy), 32'd0);
  endtask

  initial begin
    int mv, ml, dn;

    jobs[0].k = 3; jobs[0].n = 4; jobs[0].bubble = 1'b0;
    jobs[0].c = '{8'd1, 8'd2, 8'd1};
    jobs[0].x = '{8'd1, 8'd2, 8'd3, 8'd4};
    jobs[0].y = '{8'd1, 8'd4, 8'd8, 8'd12, 8'd11, 8'd4};

    jobs[1] = jobs[0];
    jobs[1].bubble = 1'b1;

    jobs[2].k = 1; jobs[2].n = 3; jobs[2].bubble = 1'b0;
    jobs[2].c = '{8'd5, 8'd0, 8'd0};
    jobs[2].x = '{8'd1, 8'd2, 8'd3, 8'd0};
    jobs[2].y = '{8'd5, 8'd10, 8'd15, 8'd0, 8'd0, 8'd0};

    jobs[3].k = 2; jobs[3].n = 2; jobs[3].bubble = 1'b0;
    jobs[3].c = '{8'd3, 8'd1, 8'd0};
    jobs[3].x = '{8'd2, 8'd5, 8'd0, 8'd0};
    jobs[3].y = '{8'd6, 8'd17, 8'd5, 8'd0, 8'd0, 8'd0};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");

    for (int j = 0; j < 4; j++) run_job(j, 1'b0);

    // Illegal configurations: K=0, K=17, N=0.
    for (int c = 0; c < 3; c++) begin
      cfg_kernel_len   = (c == 0) ? 5'd0 : (c == 1) ? 5'd17 : 5'd3;
      cfg_sample_count = (c == 2) ? CW'(0) : CW'(4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("cfg%0d_err_pulse", c), 32'(cfg_err), 32'd1);
      chk($sformatf("cfg%0d_busy", c), 32'(busy), 32'd0);
      chk($sformatf("cfg%0d_s_ready", c), 32'(s_ready), 32'd0);
      @(negedge clk);
      chk($sformatf("cfg%0d_err_clear", c), 32'(cfg_err), 32'd0);
      chk($sformatf("cfg%0d_x_valid", c), 32'(x_valid), 32'd0);
    end

    // Abort in the third STREAM cycle, then a clean job.
    load_coefs(0);
    cfg_kernel_len = 5'd3; cfg_sample_count = CW'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      s_valid = 1'b1;
      s_data  = 8'(t);
      abort   = (t == 3);
      @(negedge clk);
    end
    s_valid = 1'b0;
    abort   = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_s_ready", 32'(s_ready), 32'd0);
    chk("abort_x_valid", 32'(x_valid), 32'd0);
    mv = 0; ml = 0; dn = 0;
    for (int t = 0; t < 20; t++) begin
      mv += int'(m_valid); ml += int'(m_last); dn += int'(done);
      @(negedge clk);
    end
    chk("abort_no_m_valid", 32'(mv), 32'd0);
    chk("abort_no_m_last", 32'(ml), 32'd0);
    chk("abort_no_done", 32'(dn), 32'd0);
    run_job(0, 1'b0);

    // Write in the launch cycle and during STREAM must not disturb the job.
    run_job(0, 1'b1);

    // Next job sees the committed launch-cycle write but not the STREAM one.
    cfg_kernel_len = 5'd3; cfg_sample_count = CW'(1);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    chk("wr_commit_coef0", 32'(kernel_row_flat[7:0]), 32'd7);
    chk("wr_dropped_coef1", 32'(kernel_row_flat[15:8]), 32'd2);
    s_valid = 1'b1; s_data = 8'd3;
    repeat (4) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_s_ready", 32'(s_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    mv = 0; dn = 0;
    for (int t = 0; t < 15; t++) begin
      mv += int'(m_valid); dn += int'(done);
      @(negedge clk);
    end
    chk("postreset_no_m_valid", 32'(mv), 32'd0);
    chk("postreset_no_done", 32'(dn), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
